// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning stage.
package btn_pkg;

    localparam int unsigned N_BTN_DEFAULT           = 5;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_D = 4;

    typedef logic [1:0] sel_t;

    // Mod-4 up/down step; opposing pulses in the same cycle cancel.
    function automatic sel_t sel_step(input sel_t cur, input logic inc, input logic dec);
        sel_t nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = cur + sel_t'(1);
        end else if (dec && !inc) begin
            nxt = cur - sel_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: optional 2-flop synchronizer, stability counter, debounced level and rise pulse.
// Synchronizer present only when BTN_SYNC_EN is defined.
module debounce_cell
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;

`ifdef BTN_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_in};
        end
    end

    assign s = sync_q[1];
`else
    assign s = btn_in;
`endif

    // Any sample matching the accepted level restarts the stability count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s;
            cnt_d    = '0;
            rise_d   = s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the five board buttons and derives registered mux/demux selects and enable.
// Build option: BTN_SYNC_EN adds a 2-flop synchronizer per button.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic             enable,
    output sel_t             mux_sel,
    output sel_t             demux_sel
);

    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] rise_w;

    logic enable_q, enable_d;
    sel_t mux_q, mux_d;
    sel_t demux_q, demux_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .btn_in(btn_in[i]),
            .level (level_w[i]),
            .rise  (rise_w[i])
        );
    end

    // Control state advances one cycle after the registered rise pulse.
    always_comb begin
        enable_d = enable_q ^ rise_w[BTN_C];
        mux_d    = sel_step(mux_q, rise_w[BTN_U], rise_w[BTN_L]);
        demux_d  = sel_step(demux_q, rise_w[BTN_R], rise_w[BTN_D]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= 1'b0;
            mux_q    <= '0;
            demux_q  <= '0;
        end else begin
            enable_q <= enable_d;
            mux_q    <= mux_d;
            demux_q  <= demux_d;
        end
    end

    assign btn_level = level_w;
    assign btn_rise  = rise_w;
    assign enable    = enable_q;
    assign mux_sel   = mux_q;
    assign demux_sel = demux_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a short debounce window.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int unsigned DEB = 4;
`ifdef BTN_SYNC_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = DEB;
`endif
    localparam int GAP = LAT + 4;

    typedef struct packed {
        int         cyc;
        logic [4:0] rise;
        logic [4:0] level;
    } rise_rec_t;

    typedef struct packed {
        int   cyc;
        logic en;
        sel_t mux;
        sel_t demux;
    } state_rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_in = 5'h1F;
    logic [4:0] btn_level;
    logic [4:0] btn_rise;
    logic       enable;
    sel_t       mux_sel;
    sel_t       demux_sel;

    btn_conditioner #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .enable   (enable),
        .mux_sel  (mux_sel),
        .demux_sel(demux_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    rise_rec_t  rise_exp_q[$];
    state_rec_t state_exp_q[$];

    logic exp_en    = 1'b0;
    sel_t exp_mux   = '0;
    sel_t exp_demux = '0;

    logic [4:0] prev_state = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic expect_state(input int at, input logic en, input sel_t mux, input sel_t demux);
        if ({en, mux, demux} != {exp_en, exp_mux, exp_demux}) begin
            state_exp_q.push_back('{cyc: at, en: en, mux: mux, demux: demux});
            exp_en    = en;
            exp_mux   = mux;
            exp_demux = demux;
        end
    endtask

    // Press mask, hold, release and let the release settle.
    task automatic press(input logic [4:0] mask, input int hold,
                         input logic en, input sel_t mux, input sel_t demux);
        int k;
        step();
        btn_in = mask;
        k = cyc;
        rise_exp_q.push_back('{cyc: k + LAT, rise: mask, level: mask});
        expect_state(k + LAT + 1, en, mux, demux);
        idle(hold);
        btn_in = '0;
        idle(GAP);
    endtask

    // Monitor: any rise pulse or control-state change must match the next queued expectation.
    always @(negedge clk) begin
        rise_rec_t  got_r;
        rise_rec_t  exp_r;
        state_rec_t got_s;
        state_rec_t exp_s;
        if (rst) begin
            prev_state = {enable, mux_sel, demux_sel};
        end else begin
            if (btn_rise != '0) begin
                got_r = '{cyc: cyc, rise: btn_rise, level: btn_level};
                n_vec++;
                if (rise_exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rise_event: got rise=%b level=%b at cycle %0d, required no pulse",
                             btn_rise, btn_level, cyc);
                end else begin
                    exp_r = rise_exp_q.pop_front();
                    if (got_r != exp_r) begin
                        n_bad++;
                        $display("FAIL rise_event: got rise=%b level=%b cycle %0d, required rise=%b level=%b cycle %0d",
                                 got_r.rise, got_r.level, got_r.cyc, exp_r.rise, exp_r.level, exp_r.cyc);
                    end
                end
            end
            if ({enable, mux_sel, demux_sel} != prev_state) begin
                got_s = '{cyc: cyc, en: enable, mux: mux_sel, demux: demux_sel};
                n_vec++;
                if (state_exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL state_event: got en=%b mux=%0d demux=%0d at cycle %0d, required no change",
                             enable, mux_sel, demux_sel, cyc);
                end else begin
                    exp_s = state_exp_q.pop_front();
                    if (got_s != exp_s) begin
                        n_bad++;
                        $display("FAIL state_event: got en=%b mux=%0d demux=%0d cycle %0d, required en=%b mux=%0d demux=%0d cycle %0d",
                                 got_s.en, got_s.mux, got_s.demux, got_s.cyc,
                                 exp_s.en, exp_s.mux, exp_s.demux, exp_s.cyc);
                    end
                end
            end
            prev_state = {enable, mux_sel, demux_sel};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;

        // Reset holds everything at zero even with all buttons pressed.
        idle(4);
        check("reset_level", 32'(btn_level), 32'h0);
        check("reset_rise", 32'(btn_rise), 32'h0);
        check("reset_ctrl", 32'({enable, mux_sel, demux_sel}), 32'h0);

        // Release reset with btnU held.
        step();
        rst    = 1'b0;
        btn_in = 5'h02;
        k = cyc;
        rise_exp_q.push_back('{cyc: k + LAT, rise: 5'h02, level: 5'h02});
        expect_state(k + LAT + 1, 1'b0, 2'd1, 2'd0);
        idle(GAP);
        btn_in = '0;
        idle(GAP);

        // Short btnC glitch is rejected.
        step();
        btn_in = 5'h01;
        idle(3);
        btn_in = '0;
        idle(20);
        check("glitch_level", 32'(btn_level), 32'h0);
        check("glitch_enable", 32'(enable), 32'h0);

        // mux_sel wraps both ways.
        press(5'h02, GAP, 1'b0, 2'd2, 2'd0);
        press(5'h02, GAP, 1'b0, 2'd3, 2'd0);
        press(5'h02, GAP, 1'b0, 2'd0, 2'd0);
        press(5'h04, GAP, 1'b0, 2'd3, 2'd0);
        press(5'h02, GAP, 1'b0, 2'd0, 2'd0);

        // Simultaneous R+D cancels; then single steps and downward wrap.
        press(5'h18, GAP, 1'b0, 2'd0, 2'd0);
        press(5'h08, GAP, 1'b0, 2'd0, 2'd1);
        press(5'h10, GAP, 1'b0, 2'd0, 2'd0);
        press(5'h10, GAP, 1'b0, 2'd0, 2'd3);

        // Long hold yields one pulse; second press toggles enable back.
        press(5'h01, 100, 1'b1, 2'd0, 2'd3);
        press(5'h01, GAP, 1'b0, 2'd0, 2'd3);

        // Reset mid-debounce discards the partial count.
        step();
        btn_in = 5'h02;
        idle(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        k = cyc;
        exp_en    = 1'b0;
        exp_mux   = '0;
        exp_demux = '0;
        rise_exp_q.push_back('{cyc: k + LAT, rise: 5'h02, level: 5'h02});
        expect_state(k + LAT + 1, 1'b0, 2'd1, 2'd0);
        idle(GAP);
        btn_in = '0;
        idle(GAP);

        idle(10);
        check("rise_queue_drained", 32'(rise_exp_q.size()), 32'h0);
        check("state_queue_drained", 32'(state_exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioning stage for the board's five push-buttons, sitting directly upstream of the mux/demux top level. It synchronizes and debounces each button and produces clean levels and single-cycle press pulses. From those pulses it maintains the registered control state the datapath consumes: the mux select, the demux select and the shared enable. This replaces driving select/enable straight from raw button levels.

## Interface
Parameters:
- N_BTN, 5, number of buttons conditioned (fixed at 5 for the select logic)
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range >= 2
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; asynchronous, active-high
- btn_in  in  5  raw buttons {btnD, btnR, btnL, btnU, btnC}, bit 0 = btnC
- btn_level  out  5  debounced level per button
- btn_rise  out  5  one-cycle pulse per button on each accepted 0->1 transition
- enable  out  1  datapath enable; toggles on each btnC press
- mux_sel  out  2  mux select; +1 on btnU press, -1 on btnL press
- demux_sel  out  2  demux select; +1 on btnR press, -1 on btnD press

## Operation
- Per button, the optional synchronizer output s feeds a debounce cell holding a stable bit and a counter cnt.
- s == stable: cnt <= 0.
- s != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
- s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0.
- A glitch shorter than DEBOUNCE_CYCLES cycles restarts the counter and never changes btn_level.
- btn_rise[i] is registered and set on the same edge that stable[i] goes 0->1; it is cleared on the next edge. It never pulses on a 1->0 transition.
- enable flips on btn_rise[0].
- mux_sel and demux_sel are 2-bit, mod-4 counters: 3+1 wraps to 0 and 0-1 wraps to 3.
- Increment and decrement rise pulses in the same cycle on the same select: no change.
- Buttons held indefinitely produce exactly one rise pulse; there is no auto-repeat.

## Timing
- Reset (asynchronous assert) clears all outputs to 0: btn_level, btn_rise, enable, mux_sel, demux_sel. It also clears synchronizer flops, stable bits and counters.
- Reset asserted mid-debounce discards the partial count. After release, a pressed button needs a full 2+DEBOUNCE_CYCLES edges to register.
- Latency from an input change to btn_level/btn_rise: 2 edges (synchronizer) + DEBOUNCE_CYCLES edges, assuming the input holds steady.
- enable, mux_sel and demux_sel update on the edge after btn_rise is high, i.e. one cycle after btn_rise is visible.
- All outputs are registered; there are no combinational paths from btn_in.

## Configuration
- BTN_SYNC_EN defined: each btn_in bit passes a 2-flop synchronizer (reset to 0) before its debounce cell. Latency is 2+DEBOUNCE_CYCLES.
- BTN_SYNC_EN undefined: btn_in feeds the debounce cells directly. Latency is DEBOUNCE_CYCLES. This build is for simulation/bench only; the synthesis build defines it.

## Structure
- Package btn_pkg holds:
  - button index constants BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4
  - default DEBOUNCE_CYCLES
  - the 2-bit select typedef sel_t
- Sub-module debounce_cell is instantiated N_BTN times. It contains the synchronizer, counter, stable bit and rise register, and is parameterized by DEBOUNCE_CYCLES.
- The select/enable update logic lives in btn_conditioner itself.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 with BTN_SYNC_EN defined (latency 6 edges).
- Reset: hold rst with btn_in=5'h1F -> all outputs 0. Release rst, hold btnU -> btn_level[1]=1 and btn_rise[1] pulses on edge 6; mux_sel becomes 1 on edge 7.
- Glitch rejection: pulse btnC high for 3 cycles, then low -> btn_level, btn_rise and enable never change.
- Wrap-around: four clean btnU presses -> mux_sel 1,2,3,0. One clean btnL press from 0 -> mux_sel=3.
- Simultaneous: press btnR and btnD together (same cycle) -> demux_sel unchanged and both btn_rise bits pulse together.
- Enable toggle and hold: press and hold btnC for 100 cycles -> exactly one btn_rise[0] pulse and enable=1. Release, then press again -> enable=0.
- Reset mid-debounce: btnU high for 3 cycles, pulse rst, keep btnU high -> mux_sel stays 0 until 6 edges after rst release, then 1.
